wb_demux: RTL and testbench
===========================

# wb_demux

Write-side counterpart of the datapath's 4:1 result mux. It accepts one result word per cycle with a 2-bit destination select and steers it into one of four single-entry output holding registers. Each output is released to its consumer over a valid/ack handshake. Lane 2 is the flag lane: it stores only bit 0 of the word, mirroring the LSB masking the selector applies on read. The block sits between the ALU/writeback stage and the four destination consumers (register write port, data-memory write, flag register, branch/PC target).

## Interface
- WIDTH, 8, data word width for all lanes (lane 2 always uses only bit 0)
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  result word to distribute
- in_sel  input  2  destination lane: 0, 1, 2 (flag, LSB only) or 3
- in_valid  input  1  in_data/in_sel are valid this cycle
- in_ready  output  1  combinational; selected lane can accept this cycle
- out0, out1, out2, out3  output  WIDTH each  lane holding registers
- out_valid  output  4  bit n set: lane n holds undelivered data
- out_ack  input  4  bit n: consumer takes lane n this cycle (ignored when out_valid[n]=0)
- acc_count  output  8  number of accepted writes, wraps 255->0

## Operation
- Each lane n is a 1-entry buffer with two states, EMPTY (out_valid[n]=0) and FULL (out_valid[n]=1).
- Lane free: free[n] = !out_valid[n] | out_ack[n]. This permits same-cycle drain and refill.
- in_ready = free[in_sel]. It depends only on the currently selected lane and is independent of in_valid.
- Accept happens when in_valid & in_ready. On the next edge:
  - lane in_sel loads the word and goes FULL;
  - acc_count increments by 1, modulo 256.
- Lane 2 load value is {WIDTH-1 zeros, in_data[0]}. Lanes 0, 1 and 3 load in_data unmodified.
- Drain happens when out_valid[n] & out_ack[n] and lane n is not written in the same cycle. Lane n then goes EMPTY. Its out data register keeps the last value; it is not cleared.
- Same-cycle ack and write on the same lane: the new word is loaded and the lane stays FULL, with no bubble.
- Acks on lanes other than in_sel drain independently in the same cycle as an accept.
- When in_valid=1 and in_ready=0, nothing changes. The producer must hold in_data/in_sel stable until accepted.
- An out_ack bit on an EMPTY lane has no effect.

## Timing
- Reset values: out0-out3 = 0, out_valid = 4'b0000, acc_count = 0.
- in_ready is driven from state and out_ack only. Therefore in_ready = 1 during and right after reset for any in_sel.
- Latency: data accepted at edge k appears on outN with out_valid[N]=1 starting at edge k+1.
- Throughput: 1 word/cycle sustained to one lane if its consumer acks every cycle. 1 word/cycle across lanes when the target lanes are EMPTY.
- Reset asserted mid-operation: on the next edge all lanes go EMPTY, data registers clear to 0 and acc_count clears to 0. An accept or ack in that same cycle is discarded.
- All state updates happen on the rising edge of CLK. No combinational path from in_data to any output.

## Test plan
- Reset then single write: in_sel=1, in_data=8'hA5, in_valid=1 for one cycle -> next cycle out1=8'hA5, out_valid=4'b0010, acc_count=1; the other lanes stay 0.
- Flag lane masking: write in_sel=2, in_data=8'hFE, then in_sel=2, in_data=8'h03.
  - First: out2=8'h00. Second, after acking the first: out2=8'h01.
- Backpressure:
  - Lane 0 FULL with 8'h11, out_ack=0; present in_sel=0, 8'h22 -> in_ready=0, out0 stays 8'h11, acc_count unchanged.
  - Assert out_ack[0] -> in_ready=1 same cycle; next cycle out0=8'h22, out_valid[0]=1.
- Simultaneous events: lanes 0 and 3 FULL; out_ack=4'b1001 while writing in_sel=3, 8'h7C -> next cycle out_valid=4'b1000, out3=8'h7C, out0 retains its old value.
- Counter wrap: 256 accepted writes to lane 1 with out_ack[1] held 1 -> acc_count returns to 0, no stall cycles, out1 equals the last word.
- Reset mid-operation: lanes 0-3 FULL, Reset=1 together with a valid write and an ack -> next cycle all outputs 0, out_valid=0, acc_count=0.

Source files
------------

// File: rtl/wb_demux.sv
// wb_demux: steers one result word per cycle into one of four single-entry
// holding registers. Each register is handed to its consumer over a
// valid/ack handshake. Lane 2 is the flag lane and keeps only bit 0.
module wb_demux #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [7:0]       acc_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      state      [4];
    lane_state_t      state_next [4];
    logic [WIDTH-1:0] data_q     [4];
    logic [3:0]       free;
    logic [3:0]       load;
    logic             accept;
    logic [WIDTH-1:0] flag_word;

    // Lane availability, handshake decode and per-lane load strobes
    always_comb begin
        free      = '0;
        load      = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            free[n[1:0]] = (state[n[1:0]] == EMPTY) | out_ack[n[1:0]];
        end
        in_ready  = free[in_sel];
        accept    = in_valid & in_ready;
        for (int unsigned n = 0; n < 4; n++) begin
            load[n[1:0]] = accept & (in_sel == n[1:0]);
        end
        flag_word = {{(WIDTH-1){1'b0}}, in_data[0]};
    end

    // Next lane state: a write wins over a drain, keeping the lane FULL without a bubble
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            state_next[n[1:0]] = state[n[1:0]];
            if (load[n[1:0]]) begin
                state_next[n[1:0]] = FULL;
            end else if ((state[n[1:0]] == FULL) && out_ack[n[1:0]]) begin
                state_next[n[1:0]] = EMPTY;
            end
        end
    end

    // Lane state registers
    always_ff @(posedge CLK) begin
        for (int unsigned n = 0; n < 4; n++) begin
            if (Reset) begin
                state[n[1:0]] <= EMPTY;
            end else begin
                state[n[1:0]] <= state_next[n[1:0]];
            end
        end
    end

    // Lane data registers: hold their value across a drain, lane 2 keeps only the LSB
    always_ff @(posedge CLK) begin
        for (int unsigned n = 0; n < 4; n++) begin
            if (Reset) begin
                data_q[n[1:0]] <= '0;
            end else if (load[n[1:0]]) begin
                data_q[n[1:0]] <= (n == 2) ? flag_word : in_data;
            end
        end
    end

    // Accepted-write counter, wraps naturally at 8 bits
    always_ff @(posedge CLK) begin
        if (Reset) begin
            acc_count <= '0;
        end else if (accept) begin
            acc_count <= acc_count + 8'd1;
        end
    end

    // Output decode from lane state and data registers
    always_comb begin
        out_valid = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            out_valid[n[1:0]] = (state[n[1:0]] == FULL);
        end
        out0 = data_q[0];
        out1 = data_q[1];
        out2 = data_q[2];
        out3 = data_q[3];
    end

endmodule

// File: tb/tb_wb_demux.sv
// Testbench for wb_demux: directed scenarios followed by randomized traffic,
// all checked against a lane-level behavioural model.
module tb_wb_demux;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ack;
    logic [7:0] acc_count;

    wb_demux #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .acc_count (acc_count)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0] exp_data [4];
    logic [3:0] exp_valid;
    logic [7:0] exp_cnt;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) exp_data[n] = 8'h00;
        exp_valid = 4'b0000;
        exp_cnt   = 8'h00;
    endtask

    // One clock of the behavioural model, written from the lane rules
    task automatic model_step(input logic rst, input logic [7:0] d, input logic [1:0] s,
                              input logic v, input logic [3:0] a);
        logic acc;
        if (rst) begin
            model_reset();
        end else begin
            acc = v && (!exp_valid[s] || a[s]);
            exp_valid = exp_valid & ~a;
            if (acc) begin
                exp_valid[s] = 1'b1;
                exp_data[s]  = (s == 2'd2) ? (d & 8'h01) : d;
                exp_cnt      = exp_cnt + 8'd1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out0", out0, exp_data[0]);
        chk("out1", out1, exp_data[1]);
        chk("out2", out2, exp_data[2]);
        chk("out3", out3, exp_data[3]);
        chk("out_valid", out_valid, exp_valid);
        chk("acc_count", acc_count, exp_cnt);
    endtask

    // Drive one cycle, check in_ready before the edge and all outputs after it
    task automatic cycle(input logic rst, input logic [7:0] d, input logic [1:0] s,
                         input logic v, input logic [3:0] a);
        Reset    = rst;
        in_data  = d;
        in_sel   = s;
        in_valid = v;
        out_ack  = a;
        #1;
        chk("in_ready", in_ready, !exp_valid[s] || a[s]);
        model_step(rst, d, s, v, a);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] start_cnt;
        logic [7:0] last_word;
        logic [7:0] rd;
        logic [1:0] rs;
        logic       rv;
        logic [3:0] ra;
        logic       hold;
        logic       rr;

        Reset = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ack = '0;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset state, in_ready high for any select while in reset
        cycle(1'b1, 8'hFF, 2'd0, 1'b1, 4'b1111);
        cycle(1'b1, 8'h12, 2'd3, 1'b0, 4'b0000);
        chk("reset_valid", out_valid, 4'b0000);

        // Single write to lane 1
        cycle(1'b0, 8'hA5, 2'd1, 1'b1, 4'b0000);
        chk("single_out1", out1, 8'hA5);
        chk("single_valid", out_valid, 4'b0010);
        chk("single_cnt", acc_count, 8'd1);

        // Flag lane keeps only bit 0
        cycle(1'b0, 8'hFE, 2'd2, 1'b1, 4'b0000);
        chk("flag_first", out2, 8'h00);
        cycle(1'b0, 8'h03, 2'd2, 1'b1, 4'b0100);
        chk("flag_second", out2, 8'h01);

        // Backpressure on lane 0, then same-cycle drain and refill
        cycle(1'b0, 8'h11, 2'd0, 1'b1, 4'b0000);
        cycle(1'b0, 8'h22, 2'd0, 1'b1, 4'b0000);
        chk("bp_hold_out0", out0, 8'h11);
        chk("bp_hold_cnt", acc_count, 8'd4);
        cycle(1'b0, 8'h22, 2'd0, 1'b1, 4'b0001);
        chk("bp_refill_out0", out0, 8'h22);

        // Drain lanes 1 and 2 (an ack on empty lane 3 is ignored), fill lane 3
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1110);
        cycle(1'b0, 8'h55, 2'd3, 1'b1, 4'b0000);
        // Simultaneous drain of lane 0 and drain+refill of lane 3
        cycle(1'b0, 8'h7C, 2'd3, 1'b1, 4'b1001);
        chk("simul_valid", out_valid, 4'b1000);
        chk("simul_out3", out3, 8'h7C);
        chk("simul_out0", out0, 8'h22);

        // 256 back-to-back writes to lane 1 with continuous ack: counter wraps
        start_cnt = acc_count;
        last_word = 8'h00;
        for (int i = 0; i < 256; i++) begin
            last_word = 8'($urandom);
            cycle(1'b0, last_word, 2'd1, 1'b1, 4'b0010);
        end
        chk("wrap_cnt", acc_count, start_cnt);
        chk("wrap_out1", out1, last_word);

        // Fill every lane then reset alongside a write and an ack
        cycle(1'b0, 8'hC1, 2'd0, 1'b1, 4'b0000);
        cycle(1'b0, 8'hC2, 2'd1, 1'b1, 4'b0000);
        cycle(1'b0, 8'hC3, 2'd2, 1'b1, 4'b0000);
        chk("all_full", out_valid, 4'b1111);
        cycle(1'b1, 8'hEE, 2'd0, 1'b1, 4'b0001);
        chk("midreset_valid", out_valid, 4'b0000);
        chk("midreset_cnt", acc_count, 8'd0);
        chk("midreset_out3", out3, 8'd0);

        // Randomized traffic; producer holds a word until it is accepted
        hold = 1'b0;
        rd = '0; rs = '0; rv = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                rd = 8'($urandom);
                rs = 2'($urandom_range(0, 3));
                rv = ($urandom_range(0, 3) != 0);
            end
            ra = 4'($urandom);
            rr = ($urandom_range(0, 63) == 0);
            hold = rv && !rr && exp_valid[rs] && !ra[rs];
            cycle(rr, rd, rs, rv, ra);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
